exu_lsu: RTL and testbench

Parametrised load/store unit for the execute stage, replacing the single-outstanding access FSM. It accepts one memory op per cycle via a valid/ready handshake and issues it to the data bus. Up to NOUT requests may be in flight; responses return in order. Load data is aligned, extended and written back with its destination register. Misaligned accesses are rejected without reaching the bus.

---
 rtl/exu_lsu_if.sv | 45 ++++
 rtl/exu_lsu.sv | 133 +++++++++++++
 tb/tb_exu_lsu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// Core-side request, data-bus and writeback signals of the execute-stage load/store unit.
// The slave modport is the LSU; the master modport is the core plus memory environment.
interface exu_lsu_if #(
  parameter int RD_W = 5
) ();
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_op_i;
  logic [31:0]     req_addr_i;
  logic [31:0]     req_wdata_i;
  logic [RD_W-1:0] req_rd_i;
  logic            misaligned_o;

  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [31:0]     mem_addr_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [31:0]     mem_wdata_o;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;

  logic            wb_valid_o;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_data_o;
  logic            busy_o;
  logic            resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, misaligned_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output wb_valid_o, wb_rd_o, wb_data_o, busy_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_op_i, req_addr_i, req_wdata_i, req_rd_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, misaligned_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, busy_o, resp_err_o
  );
endinterface

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: up to NOUT in-flight bus requests with in-order responses,
// load alignment/extension into a registered writeback, misaligned ops rejected off-bus.
module exu_lsu #(
  parameter int NOUT = 2,
  parameter int RD_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  exu_lsu_if.slave  bus
);
  localparam int PW = $clog2(NOUT);

  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count;
  logic            full, empty;

  logic            meta_load_q [NOUT];
  logic [2:0]      meta_op_q   [NOUT];
  logic [1:0]      meta_off_q  [NOUT];
  logic [RD_W-1:0] meta_rd_q   [NOUT];

  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            resp_err_q, resp_err_d;

  logic [1:0]      off;
  logic            is_b, is_h, is_w;
  logic            misaligned, mem_req, accept, pop;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic [31:0]     rshift;
  logic [31:0]     load_data;

  assign off   = bus.req_addr_i[1:0];
  assign is_b  = (bus.req_op_i[1:0] == 2'b00);
  assign is_h  = (bus.req_op_i[1:0] == 2'b01);
  assign is_w  = (bus.req_op_i[1:0] == 2'b10);

  // Pointers carry a wrap bit, so their difference is the occupancy directly.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (PW+1)'(NOUT));
  assign empty = (count == '0);

  assign misaligned = bus.req_valid_i & ((is_w & (off != 2'b00)) | (is_h & off[0]));
  assign mem_req    = bus.req_valid_i & ~full & ~misaligned;
  assign accept     = mem_req & bus.mem_gnt_i;
  assign pop        = bus.mem_rvalid_i & ~empty;

  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];

  assign bus.misaligned_o = misaligned;
  assign bus.req_ready_o  = misaligned | accept;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = {bus.req_addr_i[31:2], 2'b00};
  assign bus.mem_we_o     = bus.req_we_i;

  always_comb begin
    bus.mem_be_o    = 4'b1111;
    bus.mem_wdata_o = bus.req_wdata_i;
    if (is_b) begin
      bus.mem_be_o    = 4'b0001 << off;
      bus.mem_wdata_o = {4{bus.req_wdata_i[7:0]}};
    end else if (is_h) begin
      bus.mem_be_o    = 4'b0011 << off;
      bus.mem_wdata_o = {2{bus.req_wdata_i[15:0]}};
    end
  end

  // Lane select uses the offset captured at issue, not the current request.
  assign rshift = bus.mem_rdata_i >> {meta_off_q[rd_idx], 3'b000};

  always_comb begin
    load_data = bus.mem_rdata_i;
    case (meta_op_q[rd_idx])
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  load_data = {24'h0, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  load_data = {16'h0, rshift[15:0]};
      default: load_data = bus.mem_rdata_i;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (PW+1)'(accept);
    rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
    wb_valid_d = pop & meta_load_q[rd_idx];
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (pop && meta_load_q[rd_idx]) begin
      wb_rd_d   = meta_rd_q[rd_idx];
      wb_data_d = load_data;
    end
    resp_err_d = resp_err_q | (bus.mem_rvalid_i & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < NOUT; i++) begin
        meta_load_q[i] <= 1'b0;
        meta_op_q[i]   <= '0;
        meta_off_q[i]  <= '0;
        meta_rd_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      resp_err_q <= resp_err_d;
      if (accept) begin
        meta_load_q[wr_idx] <= ~bus.req_we_i;
        meta_op_q[wr_idx]   <= bus.req_op_i;
        meta_off_q[wr_idx]  <= off;
        meta_rd_q[wr_idx]   <= bus.req_rd_i;
      end
    end
  end

  assign bus.wb_valid_o = wb_valid_q;
  assign bus.wb_rd_o    = wb_rd_q;
  assign bus.wb_data_o  = wb_data_q;
  assign bus.busy_o     = ~empty;
  assign bus.resp_err_o = resp_err_q;
endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu: request-side decode table, load/store round trips,
// outstanding-limit, stray-response and reset corner cases.
module tb_exu_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  exu_lsu_if #(.RD_W(5)) bus ();

  exu_lsu #(.NOUT(2), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic        req;
    logic        ready;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } req_vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        wbv;
    logic [31:0] wbdata;
  } rt_vec_t;

  req_vec_t rq[9];
  rt_vec_t  rt[7];

  task automatic idle();
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_op_i     = 3'b010;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.req_rd_i     = 5'd0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input logic gnt);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_op_i    = op;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_rd_i    = rd;
    bus.mem_gnt_i   = gnt;
  endtask

  task automatic round_trip(input rt_vec_t v, input int idx);
    @(negedge clk);
    drive_req(v.we, v.op, v.addr, 32'h0, v.rd, 1'b1);
    #1;
    chk($sformatf("rt%0d_be", idx), {28'h0, bus.mem_be_o}, {28'h0, v.be});
    chk($sformatf("rt%0d_req", idx), {31'h0, bus.mem_req_o}, 32'd1);
    @(negedge clk);
    idle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = v.rdata;
    #1;
    chk($sformatf("rt%0d_busy", idx), {31'h0, bus.busy_o}, 32'd1);
    chk($sformatf("rt%0d_wbv_early", idx), {31'h0, bus.wb_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("rt%0d_wbv", idx), {31'h0, bus.wb_valid_o}, {31'h0, v.wbv});
    if (v.wbv) begin
      chk($sformatf("rt%0d_wbdata", idx), bus.wb_data_o, v.wbdata);
      chk($sformatf("rt%0d_wbrd", idx), {27'h0, bus.wb_rd_o}, {27'h0, v.rd});
    end
    chk($sformatf("rt%0d_busy_after", idx), {31'h0, bus.busy_o}, 32'd0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk($sformatf("rt%0d_wbv_pulse", idx), {31'h0, bus.wb_valid_o}, 32'd0);
  endtask

  initial begin
    //          we    op      addr          wdata         mis   req   rdy   be       mwdata
    rq[0] = '{1'b0, 3'b000, 32'h0000_1003, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h0000_0000};
    rq[1] = '{1'b0, 3'b101, 32'h0000_2002, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_0000};
    rq[2] = '{1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hABAB_ABAB};
    rq[3] = '{1'b1, 3'b001, 32'h0000_0012, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h5678_5678};
    rq[4] = '{1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    rq[5] = '{1'b0, 3'b010, 32'h0000_1002, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0000_0000};
    rq[6] = '{1'b0, 3'b001, 32'h0000_1001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'b0110, 32'h0000_0000};
    rq[7] = '{1'b0, 3'b101, 32'h0000_1003, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'b1000, 32'h0000_0000};
    rq[8] = '{1'b1, 3'b000, 32'h0000_0003, 32'h0000_00CD, 1'b0, 1'b1, 1'b0, 4'b1000, 32'hCDCD_CDCD};

    //          we    op      addr           rd     rdata          be       wbv   wbdata
    rt[0] = '{1'b0, 3'b000, 32'h0000_1003, 5'd5,  32'h80FF_0000, 4'b1000, 1'b1, 32'hFFFF_FF80};
    rt[1] = '{1'b0, 3'b101, 32'h0000_2002, 5'd6,  32'hBEEF_1234, 4'b1100, 1'b1, 32'h0000_BEEF};
    rt[2] = '{1'b0, 3'b001, 32'h0000_2002, 5'd7,  32'hBEEF_1234, 4'b1100, 1'b1, 32'hFFFF_BEEF};
    rt[3] = '{1'b0, 3'b100, 32'h0000_1001, 5'd8,  32'h0000_9A00, 4'b0010, 1'b1, 32'h0000_009A};
    rt[4] = '{1'b0, 3'b010, 32'h0000_3000, 5'd9,  32'h1234_5678, 4'b1111, 1'b1, 32'h1234_5678};
    rt[5] = '{1'b0, 3'b001, 32'h0000_0000, 5'd10, 32'h0000_7FFF, 4'b0011, 1'b1, 32'h0000_7FFF};
    rt[6] = '{1'b1, 3'b000, 32'h0000_0011, 5'd11, 32'h0000_0000, 4'b0010, 1'b0, 32'h0000_0000};

    idle();
    #1;
    chk("rst_wbv", {31'h0, bus.wb_valid_o}, 32'd0);
    chk("rst_wbrd", {27'h0, bus.wb_rd_o}, 32'd0);
    chk("rst_wbdata", bus.wb_data_o, 32'd0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'd0);
    chk("rst_err", {31'h0, bus.resp_err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Request-side decode with grant low: nothing is accepted.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_req(rq[i].we, rq[i].op, rq[i].addr, rq[i].wdata, 5'd1, 1'b0);
      #1;
      chk($sformatf("rq%0d_mis", i), {31'h0, bus.misaligned_o}, {31'h0, rq[i].mis});
      chk($sformatf("rq%0d_req", i), {31'h0, bus.mem_req_o}, {31'h0, rq[i].req});
      chk($sformatf("rq%0d_ready", i), {31'h0, bus.req_ready_o}, {31'h0, rq[i].ready});
      chk($sformatf("rq%0d_be", i), {28'h0, bus.mem_be_o}, {28'h0, rq[i].be});
      chk($sformatf("rq%0d_wdata", i), bus.mem_wdata_o, rq[i].mwdata);
      chk($sformatf("rq%0d_we", i), {31'h0, bus.mem_we_o}, {31'h0, rq[i].we});
      chk($sformatf("rq%0d_addr", i), bus.mem_addr_o, {rq[i].addr[31:2], 2'b00});
    end
    @(negedge clk);
    idle();

    for (int i = 0; i < 7; i++) round_trip(rt[i], i);

    // Misaligned LW with grant high must not enter the FIFO.
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd3, 1'b1);
    #1;
    chk("mis_gnt_ready", {31'h0, bus.req_ready_o}, 32'd1);
    chk("mis_gnt_req", {31'h0, bus.mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_gnt_busy", {31'h0, bus.busy_o}, 32'd0);
    @(negedge clk);
    idle();

    // Three back-to-back LWs against NOUT=2.
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd2, 1'b1);
    #1;
    chk("b2b_req2", {31'h0, bus.mem_req_o}, 32'd1);
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0108, 32'h0, 5'd3, 1'b1);
    #1;
    chk("b2b_full_req", {31'h0, bus.mem_req_o}, 32'd0);
    chk("b2b_full_ready", {31'h0, bus.req_ready_o}, 32'd0);
    chk("b2b_full_busy", {31'h0, bus.busy_o}, 32'd1);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hAAAA_0001;
    #1;
    chk("b2b_full_pop_req", {31'h0, bus.mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_wb1_v", {31'h0, bus.wb_valid_o}, 32'd1);
    chk("b2b_wb1_rd", {27'h0, bus.wb_rd_o}, 32'd1);
    chk("b2b_wb1_data", bus.wb_data_o, 32'hAAAA_0001);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("b2b_third_req", {31'h0, bus.mem_req_o}, 32'd1);
    chk("b2b_third_ready", {31'h0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    idle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hAAAA_0002;
    @(posedge clk);
    #1;
    chk("b2b_wb2_rd", {27'h0, bus.wb_rd_o}, 32'd2);
    chk("b2b_wb2_data", bus.wb_data_o, 32'hAAAA_0002);
    @(negedge clk);
    bus.mem_rdata_i = 32'hAAAA_0003;
    @(posedge clk);
    #1;
    chk("b2b_wb3_rd", {27'h0, bus.wb_rd_o}, 32'd3);
    chk("b2b_wb3_data", bus.wb_data_o, 32'hAAAA_0003);
    chk("b2b_idle_busy", {31'h0, bus.busy_o}, 32'd0);
    @(negedge clk);
    idle();

    // Stray response: sticky error, no writeback.
    @(negedge clk);
    chk("err_pre", {31'h0, bus.resp_err_o}, 32'd0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_5555;
    @(posedge clk);
    #1;
    chk("err_set", {31'h0, bus.resp_err_o}, 32'd1);
    chk("err_no_wb", {31'h0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", {31'h0, bus.resp_err_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("err_clr", {31'h0, bus.resp_err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with a load in flight, then its late response.
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("midrst_busy", {31'h0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_clr", {31'h0, bus.busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_late_err", {31'h0, bus.resp_err_o}, 32'd1);
    chk("midrst_late_wbv", {31'h0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
